// File: rtl/sh7604_rst_ctrl.sv
// Reset and standby sequencer for the SH7604 peripheral cluster: merges external, WDT and
// standby requests into registered reset/standby strobes and times NMI oscillator settling.
module sh7604_rst_ctrl #(
   parameter int unsigned POR_CYCLES    = 16,
   parameter int unsigned WRES_CYCLES   = 8,
   parameter int unsigned SETTLE_CYCLES = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE_R,
   input  logic       EN,
   input  logic       CLK512_CE,
   input  logic       EXT_RES_N,
   input  logic       WDT_PRES,
   input  logic       WDT_MRES,
   input  logic       SLEEP_REQ,
   input  logic       NMI,
   output logic       SYS_RES_N,
   output logic       PRES_N,
   output logic       MRES_N,
   output logic       SBY,
   output logic       STBY_WAKE,
   output logic [1:0] RST_CAUSE
);

   localparam logic [2:0] StExtHold  = 3'd0;
   localparam logic [2:0] StRun      = 3'd1;
   localparam logic [2:0] StPresHold = 3'd2;
   localparam logic [2:0] StMresHold = 3'd3;
   localparam logic [2:0] StStandby  = 3'd4;
   localparam logic [2:0] StSettle   = 3'd5;

   localparam logic [1:0] CauseExt  = 2'b00;
   localparam logic [1:0] CausePres = 2'b01;
   localparam logic [1:0] CauseMres = 2'b10;

   localparam logic [7:0] PorLoad    = 8'(POR_CYCLES);
   localparam logic [7:0] WresLoad   = 8'(WRES_CYCLES);
   localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] cause_q, cause_d;
   logic       nmi_q, nmi_d;
   logic       sys_res_n_q, sys_res_n_d;
   logic       pres_n_q, pres_n_d;
   logic       mres_n_q, mres_n_d;
   logic       sby_q, sby_d;
   logic       wake_q, wake_d;
   logic       tick;
   logic       nmi_rise;

   assign tick     = EN & CE_R;
   assign nmi_rise = NMI & ~nmi_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      nmi_d   = nmi_q;
      wake_d  = wake_q;
      if (tick) begin
         nmi_d  = NMI;
         wake_d = 1'b0;
         if (!EXT_RES_N) begin
            state_d = StExtHold;
            cnt_d   = PorLoad;
            cause_d = CauseExt;
         end else begin
            case (state_q)
               StExtHold: begin
                  if (cnt_q == 8'd1) state_d = StRun;
                  else               cnt_d   = cnt_q - 8'd1;
               end
               StRun: begin
                  if (WDT_PRES) begin
                     state_d = StPresHold;
                     cnt_d   = WresLoad;
                     cause_d = CausePres;
                  end else if (WDT_MRES) begin
                     state_d = StMresHold;
                     cnt_d   = WresLoad;
                     cause_d = CauseMres;
                  end else if (SLEEP_REQ) begin
                     state_d = StStandby;
                  end
               end
               StPresHold: begin
                  if (WDT_PRES)            cnt_d   = WresLoad;
                  else if (cnt_q == 8'd1)  state_d = StRun;
                  else                     cnt_d   = cnt_q - 8'd1;
               end
               StMresHold: begin
                  // A power-on request outranks the manual hold already in progress.
                  if (WDT_PRES) begin
                     state_d = StPresHold;
                     cnt_d   = WresLoad;
                     cause_d = CausePres;
                  end else if (WDT_MRES) begin
                     cnt_d   = WresLoad;
                  end else if (cnt_q == 8'd1) begin
                     state_d = StRun;
                  end else begin
                     cnt_d   = cnt_q - 8'd1;
                  end
               end
               StStandby: begin
                  if (nmi_rise) begin
                     state_d = StSettle;
                     cnt_d   = SettleLoad;
                  end
               end
               StSettle: begin
                  if (CLK512_CE) begin
                     if (cnt_q == 8'd1) begin
                        state_d = StRun;
                        wake_d  = 1'b1;
                     end else begin
                        cnt_d = cnt_q - 8'd1;
                     end
                  end
               end
               default: begin
                  state_d = StExtHold;
                  cnt_d   = PorLoad;
                  cause_d = CauseExt;
               end
            endcase
         end
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      sys_res_n_d = (state_d != StExtHold);
      pres_n_d    = (state_d != StExtHold) && (state_d != StPresHold);
      mres_n_d    = (state_d != StMresHold);
      sby_d       = (state_d == StStandby) || (state_d == StSettle);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StExtHold;
         cnt_q       <= PorLoad;
         cause_q     <= CauseExt;
         nmi_q       <= 1'b0;
         sys_res_n_q <= 1'b0;
         pres_n_q    <= 1'b0;
         mres_n_q    <= 1'b1;
         sby_q       <= 1'b0;
         wake_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         nmi_q       <= nmi_d;
         sys_res_n_q <= sys_res_n_d;
         pres_n_q    <= pres_n_d;
         mres_n_q    <= mres_n_d;
         sby_q       <= sby_d;
         wake_q      <= wake_d;
      end
   end

   assign SYS_RES_N = sys_res_n_q;
   assign PRES_N    = pres_n_q;
   assign MRES_N    = mres_n_q;
   assign SBY       = sby_q;
   assign STBY_WAKE = wake_q;
   assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_sh7604_rst_ctrl.sv
// Directed bench for sh7604_rst_ctrl: reset timing, WDT holds, standby/settle, abort and enable.
module tb_sh7604_rst_ctrl;

   localparam int unsigned TbPor    = 16;
   localparam int unsigned TbWres   = 8;
   localparam int unsigned TbSettle = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CE_R, EN, CLK512_CE, EXT_RES_N, WDT_PRES, WDT_MRES, SLEEP_REQ, NMI;
   logic       SYS_RES_N, PRES_N, MRES_N, SBY, STBY_WAKE;
   logic [1:0] RST_CAUSE;

   int n_checks = 0;
   int n_errors = 0;
   int wake_seen = 0;

   sh7604_rst_ctrl #(
      .POR_CYCLES   (TbPor),
      .WRES_CYCLES  (TbWres),
      .SETTLE_CYCLES(TbSettle)
   ) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .CE_R     (CE_R),
      .EN       (EN),
      .CLK512_CE(CLK512_CE),
      .EXT_RES_N(EXT_RES_N),
      .WDT_PRES (WDT_PRES),
      .WDT_MRES (WDT_MRES),
      .SLEEP_REQ(SLEEP_REQ),
      .NMI      (NMI),
      .SYS_RES_N(SYS_RES_N),
      .PRES_N   (PRES_N),
      .MRES_N   (MRES_N),
      .SBY      (SBY),
      .STBY_WAKE(STBY_WAKE),
      .RST_CAUSE(RST_CAUSE)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      if (STBY_WAKE) wake_seen++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic get_sig(input int sel);
      case (sel)
         0:       return SYS_RES_N;
         1:       return PRES_N;
         2:       return MRES_N;
         default: return SBY;
      endcase
   endfunction

   // Ticks until the selected output reaches val; n is the tick count (max if it never does).
   task automatic run_until(input int sel, input logic val, input int max, output int n);
      n = 0;
      while (get_sig(sel) !== val && n < max) begin
         tick();
         n++;
      end
   endtask

   int n;
   int ce_cnt;
   int early_wake;

   initial begin
      if (TbPor == 0 || TbWres == 0 || TbSettle == 0) $fatal(1, "zero cycle parameter is illegal");
      RST = 1'b1; CE_R = 1'b1; EN = 1'b1; CLK512_CE = 1'b0; EXT_RES_N = 1'b1;
      WDT_PRES = 1'b0; WDT_MRES = 1'b0; SLEEP_REQ = 1'b0; NMI = 1'b0;
      #12;
      check_eq("rst_sys_res_n", SYS_RES_N, 0);
      check_eq("rst_pres_n", PRES_N, 0);
      check_eq("rst_mres_n", MRES_N, 1);
      check_eq("rst_sby", SBY, 0);
      check_eq("rst_wake", STBY_WAKE, 0);
      check_eq("rst_cause", RST_CAUSE, 0);

      // Power-on hold after RST release.
      @(posedge CLK); #1;
      RST = 1'b0;
      run_until(0, 1'b1, 40, n);
      check_eq("por_len", n, 16);
      check_eq("por_pres_n", PRES_N, 1);
      check_eq("por_cause", RST_CAUSE, 0);

      // WDT power-on request held 5 ticks.
      tick();
      WDT_PRES = 1'b1;
      tick();
      check_eq("pres_low", PRES_N, 0);
      check_eq("pres_sys_hi", SYS_RES_N, 1);
      check_eq("pres_cause", RST_CAUSE, 1);
      ticks(4);
      WDT_PRES = 1'b0;
      run_until(1, 1'b1, 40, n);
      check_eq("pres_len", n + 5, 13);
      check_eq("pres_sys_stay", SYS_RES_N, 1);

      // Simultaneous PRES and MRES: PRES wins.
      tick();
      WDT_PRES = 1'b1; WDT_MRES = 1'b1;
      tick();
      check_eq("both_pres_n", PRES_N, 0);
      check_eq("both_mres_n", MRES_N, 1);
      check_eq("both_cause", RST_CAUSE, 1);
      tick();
      WDT_PRES = 1'b0; WDT_MRES = 1'b0;
      run_until(1, 1'b1, 40, n);
      check_eq("both_tail", n, 8);

      // MRES alone for 5 ticks.
      tick();
      WDT_MRES = 1'b1;
      tick();
      check_eq("mres_low", MRES_N, 0);
      check_eq("mres_pres_hi", PRES_N, 1);
      check_eq("mres_cause", RST_CAUSE, 2);
      ticks(4);
      WDT_MRES = 1'b0;
      run_until(2, 1'b1, 40, n);
      check_eq("mres_len", n + 5, 13);

      // MRES upgraded to PRES mid-hold.
      WDT_MRES = 1'b1;
      ticks(2);
      WDT_PRES = 1'b1;
      tick();
      check_eq("upg_pres_n", PRES_N, 0);
      check_eq("upg_mres_n", MRES_N, 1);
      check_eq("upg_cause", RST_CAUSE, 1);
      WDT_PRES = 1'b0; WDT_MRES = 1'b0;
      run_until(1, 1'b1, 40, n);
      check_eq("upg_tail", n, 8);

      // Standby entry and NMI wake with CLK512_CE every 3rd tick.
      SLEEP_REQ = 1'b1;
      tick();
      SLEEP_REQ = 1'b0;
      check_eq("sby_enter", SBY, 1);
      NMI = 1'b1;
      tick();
      check_eq("settle_sby", SBY, 1);
      ce_cnt = 0;
      early_wake = 0;
      for (int j = 0; j < 40; j++) begin
         CLK512_CE = (j % 3 == 2);
         tick();
         if (CLK512_CE) ce_cnt++;
         if (!SBY) break;
         if (STBY_WAKE) early_wake++;
      end
      check_eq("settle_ce_ticks", ce_cnt, 4);
      check_eq("settle_sby_off", SBY, 0);
      check_eq("wake_pulse", STBY_WAKE, 1);
      check_eq("wake_early", early_wake, 0);
      CLK512_CE = 1'b0; NMI = 1'b0;
      tick();
      check_eq("wake_one_tick", STBY_WAKE, 0);
      check_eq("wake_cause", RST_CAUSE, 1);

      // External reset aborting SETTLE.
      SLEEP_REQ = 1'b1;
      tick();
      SLEEP_REQ = 1'b0;
      NMI = 1'b1;
      tick();
      CLK512_CE = 1'b1;
      ticks(2);
      check_eq("abort_pre_sby", SBY, 1);
      wake_seen = 0;
      EXT_RES_N = 1'b0;
      tick();
      check_eq("abort_sby", SBY, 0);
      check_eq("abort_sys", SYS_RES_N, 0);
      check_eq("abort_cause", RST_CAUSE, 0);
      ticks(2);
      EXT_RES_N = 1'b1;
      run_until(0, 1'b1, 40, n);
      check_eq("abort_hold", n, 16);
      check_eq("abort_no_wake", wake_seen, 0);
      CLK512_CE = 1'b0;

      // EN low for 10 cycles stretches the external hold.
      EXT_RES_N = 1'b0;
      tick();
      EXT_RES_N = 1'b1;
      ticks(5);
      EN = 1'b0;
      ticks(10);
      check_eq("en_frozen", SYS_RES_N, 0);
      EN = 1'b1;
      run_until(0, 1'b1, 40, n);
      check_eq("en_total", n + 15, 26);

      // NMI edge in RUN is not remembered into standby.
      NMI = 1'b0;
      tick();
      NMI = 1'b1;
      tick();
      SLEEP_REQ = 1'b1;
      tick();
      SLEEP_REQ = 1'b0;
      ticks(3);
      check_eq("nmi_not_kept", SBY, 1);

      // WDT requests are ignored in standby.
      WDT_PRES = 1'b1;
      ticks(3);
      check_eq("sby_pres_n", PRES_N, 1);
      check_eq("sby_hold", SBY, 1);
      check_eq("sby_cause", RST_CAUSE, 0);
      WDT_PRES = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sh7604_rst_ctrl.md
# sh7604_rst_ctrl

Reset and standby sequencer for the SH7604 on-chip peripheral cluster. It merges the external reset pin, the watchdog's power-on (PRES) and manual (MRES) reset requests, and the CPU's standby request into registered reset and standby strobes. Those strobes drive the CPU core, the WDT (`RES_N`, `SBY`) and the other on-chip modules. It also times oscillator settling on NMI wake-up from standby.

## Interface
Parameters:
- POR_CYCLES, 16: CE_R ticks `SYS_RES_N`/`PRES_N` stay low after external reset release (1..255)
- WRES_CYCLES, 8: CE_R ticks `PRES_N`/`MRES_N` stay low after WDT request drops (1..255)
- SETTLE_CYCLES, 64: CLK512_CE ticks spent in settle before leaving standby (1..255)

Ports (clock and reset first):
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- CE_R  in  1  rising-phase clock enable; all state updates are qualified by `EN && CE_R`
- EN  in  1  block enable; when 0, state and outputs hold
- CLK512_CE  in  1  prescaler tick used for the settle count
- EXT_RES_N  in  1  external reset pin, already synchronised, active low
- WDT_PRES  in  1  WDT power-on reset request (level, several CE_R ticks wide)
- WDT_MRES  in  1  WDT manual reset request (level)
- SLEEP_REQ  in  1  one-tick pulse: CPU executed SLEEP with SBYCR.SBY=1
- NMI  in  1  NMI pin level, synchronised; the wake event is its rising edge
- SYS_RES_N  out  1  low: reset of all modules including the WDT
- PRES_N  out  1  low: power-on type reset of CPU core and non-WDT modules
- MRES_N  out  1  low: manual reset of CPU core only
- SBY  out  1  standby active; to WDT `SBY` and module clock gating
- STBY_WAKE  out  1  one CE_R-tick pulse on return to RUN from standby
- RST_CAUSE  out  2  last reset source: 00 external, 01 WDT PRES, 10 WDT MRES; held until the next reset

## Operation
- FSM states: EXT_HOLD, RUN, PRES_HOLD, MRES_HOLD, STANDBY, SETTLE. An 8-bit down counter CNT is shared by all timed states.
- Every output is registered and decoded from the next state. There are no combinational paths from inputs to outputs.
- Output map:
  - EXT_HOLD: `SYS_RES_N`=0, `PRES_N`=0.
  - PRES_HOLD: `PRES_N`=0, `SYS_RES_N`=1.
  - MRES_HOLD: `MRES_N`=0.
  - STANDBY and SETTLE: `SBY`=1.
  - All other outputs are inactive (resets 1, `SBY` 0).
- Transitions, evaluated on each `EN && CE_R` tick in priority order:
  1. `EXT_RES_N`=0 in any state -> EXT_HOLD, CNT=POR_CYCLES, RST_CAUSE=00.
  2. EXT_HOLD with pin high: decrement CNT. The tick on which CNT==1 goes to RUN, so the hold is exactly POR_CYCLES ticks after release.
  3. RUN with `WDT_PRES`=1 -> PRES_HOLD, RST_CAUSE=01. `WDT_PRES` wins over a simultaneous `WDT_MRES`.
  4. RUN with `WDT_MRES`=1 -> MRES_HOLD, RST_CAUSE=10.
  5. PRES_HOLD / MRES_HOLD: CNT is reloaded to WRES_CYCLES on every tick while the request is high. After the request drops, the hold lasts exactly WRES_CYCLES more ticks, then goes to RUN. A PRES arriving during MRES_HOLD upgrades the state to PRES_HOLD with a reload.
  6. RUN with `SLEEP_REQ`=1 and no WDT request -> STANDBY. If SLEEP_REQ coincides with a WDT request, the request wins and SLEEP_REQ is dropped.
  7. STANDBY: a rising edge of NMI (the edge register is updated on CE_R ticks) -> SETTLE, CNT=SETTLE_CYCLES. `WDT_PRES`/`WDT_MRES` are ignored in STANDBY and SETTLE.
  8. SETTLE: CNT decrements on ticks where CLK512_CE=1. On the tick where CNT==1 and CLK512_CE=1, go to RUN with `STBY_WAKE`=1 for that one tick.
- SLEEP_REQ outside RUN is ignored. An NMI edge outside STANDBY is ignored and is not remembered.

## Timing
- On `RST` assertion, asynchronously: state=EXT_HOLD, CNT=POR_CYCLES, `SYS_RES_N`=0, `PRES_N`=0, `MRES_N`=1, `SBY`=0, `STBY_WAKE`=0, RST_CAUSE=00, NMI edge register=0.
- After `RST` deasserts with `EXT_RES_N`=1, outputs release on the POR_CYCLES-th CE_R tick.
- Input-to-output latency is one qualifying tick: an input seen on tick k changes the outputs after the CLK edge of tick k.
- `EXT_RES_N` going low during SETTLE or a WDT hold aborts the operation immediately (next tick) and restarts POR timing.
- With `EN`=0, CNT and state are frozen and outputs hold their values. `RST` still acts asynchronously.
- CNT never wraps, because every load is at least 1. A parameter value of 0 is illegal; the bench asserts on it.

## Test plan
- RST pulse, `EXT_RES_N`=1, CE_R every cycle, POR_CYCLES=16 -> `SYS_RES_N`/`PRES_N` low for exactly 16 ticks after RST falls, then high; RST_CAUSE=00.
- In RUN, `WDT_PRES` high for 5 ticks, WRES_CYCLES=8 -> `PRES_N` low for 13 ticks, `SYS_RES_N` stays 1, RST_CAUSE=01.
- `WDT_PRES` and `WDT_MRES` rise on the same tick -> PRES_HOLD, `MRES_N` stays 1, RST_CAUSE=01. In a separate run, MRES alone -> `MRES_N` low for its duration + 8 ticks, RST_CAUSE=10.
- SLEEP_REQ pulse -> `SBY`=1. NMI rises, SETTLE_CYCLES=4, CLK512_CE every 3rd tick -> `SBY` falls on the 4th CLK512_CE tick, `STBY_WAKE` high exactly 1 tick, RST_CAUSE unchanged.
- SETTLE in progress, then `EXT_RES_N` low for 3 ticks -> `SBY`=0 and `SYS_RES_N`=0 on the next tick, then 16 ticks of hold after release, no `STBY_WAKE` pulse.
- `EN`=0 for 10 cycles mid-EXT_HOLD -> hold is extended by exactly those cycles. WDT_PRES asserted during STANDBY -> no effect, `PRES_N` stays 1.
